// File: rtl/mv_pkg.sv
// Shared widths, counts and FSM state encoding for the reverb microcode sequencer.
package mv_pkg;

    localparam int MV_STEPS    = 128;
    localparam int MV_STEP_W   = 7;
    localparam int MV_PROG_W   = 6;
    localparam int MV_UADDR_W  = 13;
    localparam int MV_UDATA_W  = 16;
    localparam int MV_SPRAM_AW = MV_UADDR_W + 1;
    localparam int MV_OVR_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_LOAD
    } seq_state_e;

    typedef logic [MV_STEP_W-1:0] step_t;
    typedef logic [MV_PROG_W-1:0] prog_t;

    // SPRAM word address of one step: programs occupy 128-word pages in the lower half.
    function automatic logic [MV_SPRAM_AW-1:0] run_addr(prog_t p, step_t s);
        return {1'b0, p, s};
    endfunction

endpackage

// File: rtl/mv_ucode_seq_if.sv
// Host microcode-load bus: the host (master) pushes address/data words while the
// sequencer (slave) holds ld_ready in its LOAD state.
interface mv_ucode_seq_if;
    import mv_pkg::*;

    logic                  ld_mode;
    logic [MV_UADDR_W-1:0] ld_addr;
    logic [MV_UDATA_W-1:0] ld_data;
    logic                  ld_valid;
    logic                  ld_ready;

    modport master (
        output ld_mode, ld_addr, ld_data, ld_valid,
        input  ld_ready
    );

    modport slave (
        input  ld_mode, ld_addr, ld_data, ld_valid,
        output ld_ready
    );

endinterface

// File: rtl/mv_ovr_cnt.sv
// Saturating count of dropped sample strobes; clear wins over a simultaneous increment.
module mv_ovr_cnt
    import mv_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                clr,
    output logic [MV_OVR_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mv_ucode_seq.sv
// Microcode sequencer: walks 128 SPRAM words of the latched reverb program per sample
// strobe and arbitrates host load access. Optional overrun counter: MV_SEQ_OVRCNT_EN.
module mv_ucode_seq
    import mv_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ena,
    input  logic [MV_PROG_W-1:0]   prog,
    input  logic                   ovr_clr,
    mv_ucode_seq_if.slave          ld,
    output logic [MV_SPRAM_AW-1:0] ucode_addr,
    output logic [MV_UDATA_W-1:0]  ucode_wdata,
    output logic                   ucode_we,
    output logic [MV_STEP_W-1:0]   step,
    output logic                   step_valid,
    output logic                   done,
    output logic                   busy,
    output logic                   overrun,
    output logic [MV_OVR_W-1:0]    ovr_cnt
);

    seq_state_e state_q, state_d;
    prog_t      rprog;
    step_t      iaddr;
    logic       last_issue;

    assign last_issue = (state_q == ST_RUN) && (iaddr == step_t'(MV_STEPS - 1));

    // NOTE: every signal gets its default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (ena) state_d = ST_RUN;
                      else if (ld.ld_mode) state_d = ST_LOAD;
            ST_RUN:   if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_IDLE;
            ST_LOAD:  if (!ld.ld_mode) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ucode_addr  = run_addr(rprog, '0);
        ucode_wdata = '0;
        ucode_we    = 1'b0;
        ld.ld_ready = 1'b0;
        unique case (state_q)
            ST_RUN: ucode_addr = run_addr(rprog, iaddr);
            ST_LOAD: begin
                ucode_addr  = {1'b0, ld.ld_addr};
                ucode_wdata = ld.ld_data;
                ucode_we    = ld.ld_valid;
                ld.ld_ready = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    // NOTE: state registers use non-blocking assignment so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rprog      <= '0;
            iaddr      <= '0;
            step       <= '0;
            step_valid <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && ena) begin
                rprog <= prog;
                iaddr <= '0;
            end else if (state_q == ST_RUN) begin
                iaddr <= iaddr + 1'b1;
            end
            // The SPRAM presents the word one cycle after its address is issued.
            step_valid <= (state_q == ST_RUN);
            if (state_q == ST_RUN) step <= iaddr;
            done    <= last_issue;
            overrun <= ena && (state_q != ST_IDLE);
        end
    end

`ifdef MV_SEQ_OVRCNT_EN
    mv_ovr_cnt u_ovr_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (overrun),
        .clr   (ovr_clr),
        .cnt   (ovr_cnt)
    );
`else
    logic unused_ovr_clr;
    assign unused_ovr_clr = ovr_clr;
    assign ovr_cnt        = '0;
`endif

endmodule

// File: tb/tb_mv_ucode_seq.sv
// Directed bench for mv_ucode_seq: full passes, prog change, overrun, load access and
// mid-pass reset, each checked against hand-derived cycle timing.
module tb_mv_ucode_seq;

    logic        clk = 1'b0;
    logic        reset, ena, ovr_clr;
    logic [5:0]  prog;
    logic [13:0] ucode_addr;
    logic [15:0] ucode_wdata;
    logic        ucode_we;
    logic [6:0]  step;
    logic        step_valid, done, busy, overrun;
    logic [7:0]  ovr_cnt;

    int total = 0;
    int bad   = 0;
    int exp_ovr = 0;

`ifdef MV_SEQ_OVRCNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    mv_ucode_seq_if ld_bus ();

    mv_ucode_seq dut (
        .clk         (clk),
        .reset       (reset),
        .ena         (ena),
        .prog        (prog),
        .ovr_clr     (ovr_clr),
        .ld          (ld_bus.slave),
        .ucode_addr  (ucode_addr),
        .ucode_wdata (ucode_wdata),
        .ucode_we    (ucode_we),
        .step        (step),
        .step_valid  (step_valid),
        .done        (done),
        .busy        (busy),
        .overrun     (overrun),
        .ovr_cnt     (ovr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    // One pass from an ena in the current cycle (cycle 0) through cycle 130.
    task automatic run_pass(input logic [5:0] p, input int chg_at, input logic [5:0] p2,
                            input int ena2_at, input int ld_at);
        logic [13:0] ea;
        logic        ev, ed, eo, eb;
        logic [6:0]  es;
        prog = p;
        ena  = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL pass_start_busy got=%b exp=0", busy);
        end
        for (int k = 1; k <= 130; k++) begin
            next_cyc;
            ena = (k == ena2_at);
            if (k == chg_at) prog = p2;
            if (ld_at > 0 && k == ld_at) ld_bus.ld_mode = 1'b1;
            #1;
            ea = (k <= 128) ? {1'b0, p, 7'(k - 1)} : {1'b0, p, 7'd0};
            ev = (k >= 2) && (k <= 129);
            es = 7'(k - 2);
            ed = (k == 129);
            eo = (ena2_at > 0) && (k == ena2_at + 1);
            eb = (k <= 129);
            total++;
            if (ucode_addr !== ea) begin
                bad++; $display("FAIL pass_addr k=%0d got=%h exp=%h", k, ucode_addr, ea);
            end
            total++;
            if (step_valid !== ev) begin
                bad++; $display("FAIL pass_step_valid k=%0d got=%b exp=%b", k, step_valid, ev);
            end
            if (ev) begin
                total++;
                if (step !== es) begin
                    bad++; $display("FAIL pass_step k=%0d got=%0d exp=%0d", k, step, es);
                end
            end
            total++;
            if (done !== ed) begin
                bad++; $display("FAIL pass_done k=%0d got=%b exp=%b", k, done, ed);
            end
            total++;
            if (overrun !== eo) begin
                bad++; $display("FAIL pass_overrun k=%0d got=%b exp=%b", k, overrun, eo);
            end
            total++;
            if (busy !== eb || ld_bus.ld_ready !== 1'b0 || ucode_we !== 1'b0) begin
                bad++; $display("FAIL pass_busy_ld k=%0d got busy=%b rdy=%b we=%b exp busy=%b rdy=0 we=0",
                                k, busy, ld_bus.ld_ready, ucode_we, eb);
            end
        end
        ena = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) next_cyc;
        total++;
        if (ucode_addr !== 14'h0 || ucode_wdata !== 16'h0 || ucode_we !== 1'b0 ||
            step !== 7'h0 || step_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
            overrun !== 1'b0 || ld_bus.ld_ready !== 1'b0 || ovr_cnt !== 8'h0) begin
            bad++;
            $display("FAIL reset_state got addr=%h wd=%h we=%b step=%0d sv=%b done=%b busy=%b ovr=%b rdy=%b cnt=%0d exp all zero",
                     ucode_addr, ucode_wdata, ucode_we, step, step_valid, done, busy, overrun,
                     ld_bus.ld_ready, ovr_cnt);
        end
        reset = 1'b0;
        next_cyc;
    endtask

    task automatic test_pass;
        run_pass(6'd5, 0, 6'd0, 0, 0);
        next_cyc;
    endtask

    task automatic test_prog_change;
        run_pass(6'd5, 50, 6'd9, 0, 0);
        next_cyc;
        run_pass(6'd9, 0, 6'd0, 0, 0);
        next_cyc;
    endtask

    task automatic test_overrun;
        run_pass(6'd5, 0, 6'd0, 60, 0);
        exp_ovr += CNT_ON;
        next_cyc;
        total++;
        if (ovr_cnt !== 8'(exp_ovr)) begin
            bad++; $display("FAIL ovr_cnt_after_drop got=%0d exp=%0d", ovr_cnt, exp_ovr);
        end
        ovr_clr = 1'b1;
        next_cyc;
        ovr_clr = 1'b0;
        exp_ovr = 0;
        #1;
        total++;
        if (ovr_cnt !== 8'(exp_ovr)) begin
            bad++; $display("FAIL ovr_cnt_clear got=%0d exp=%0d", ovr_cnt, exp_ovr);
        end
        next_cyc;
    endtask

    task automatic test_load;
        logic [12:0] wa [3] = '{13'h0001, 13'h0002, 13'h1FFF};
        logic [15:0] wd [3] = '{16'hAAAA, 16'h5555, 16'h1234};
        ld_bus.ld_mode = 1'b1;
        #1;
        total++;
        if (ld_bus.ld_ready !== 1'b0) begin
            bad++; $display("FAIL load_idle_ready got=%b exp=0", ld_bus.ld_ready);
        end
        next_cyc;
        total++;
        if (ld_bus.ld_ready !== 1'b1 || busy !== 1'b1 || ucode_we !== 1'b0) begin
            bad++; $display("FAIL load_enter got rdy=%b busy=%b we=%b exp 1 1 0",
                            ld_bus.ld_ready, busy, ucode_we);
        end
        for (int i = 0; i < 3; i++) begin
            ld_bus.ld_addr  = wa[i];
            ld_bus.ld_data  = wd[i];
            ld_bus.ld_valid = 1'b1;
            #1;
            total++;
            if (ucode_we !== 1'b1 || ucode_addr !== {1'b0, wa[i]} || ucode_wdata !== wd[i]) begin
                bad++; $display("FAIL load_word%0d got we=%b addr=%h data=%h exp we=1 addr=%h data=%h",
                                i, ucode_we, ucode_addr, ucode_wdata, {1'b0, wa[i]}, wd[i]);
            end
            next_cyc;
        end
        ld_bus.ld_valid = 1'b0;
        ena = 1'b1;
        #1;
        total++;
        if (ucode_we !== 1'b0) begin
            bad++; $display("FAIL load_idle_we got=%b exp=0", ucode_we);
        end
        next_cyc;
        ena = 1'b0;
        exp_ovr += CNT_ON;
        #1;
        total++;
        if (overrun !== 1'b1 || ld_bus.ld_ready !== 1'b1) begin
            bad++; $display("FAIL load_ena_drop got ovr=%b rdy=%b exp 1 1", overrun, ld_bus.ld_ready);
        end
        next_cyc;
        total++;
        if (step_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b1 || ovr_cnt !== 8'(exp_ovr)) begin
            bad++; $display("FAIL load_no_pass got sv=%b ovr=%b busy=%b cnt=%0d exp 0 0 1 %0d",
                            step_valid, overrun, busy, ovr_cnt, exp_ovr);
        end
        ld_bus.ld_mode = 1'b0;
        #1;
        total++;
        if (ld_bus.ld_ready !== 1'b1) begin
            bad++; $display("FAIL load_exit_sample got rdy=%b exp=1", ld_bus.ld_ready);
        end
        next_cyc;
        ld_bus.ld_addr  = 13'h0AAA;
        ld_bus.ld_data  = 16'hDEAD;
        ld_bus.ld_valid = 1'b1;
        #1;
        total++;
        if (ucode_we !== 1'b0 || ld_bus.ld_ready !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL load_exit_cycle got we=%b rdy=%b busy=%b exp 0 0 0",
                            ucode_we, ld_bus.ld_ready, busy);
        end
        ld_bus.ld_valid = 1'b0;
        next_cyc;
    endtask

    task automatic test_ld_during_run;
        run_pass(6'd3, 0, 6'd0, 0, 10);
        next_cyc;
        total++;
        if (ld_bus.ld_ready !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL ld_after_done got rdy=%b busy=%b exp 1 1", ld_bus.ld_ready, busy);
        end
        ld_bus.ld_mode = 1'b0;
        next_cyc;
        total++;
        if (ld_bus.ld_ready !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL ld_release got rdy=%b busy=%b exp 0 0", ld_bus.ld_ready, busy);
        end
        next_cyc;
    endtask

    task automatic test_reset_mid;
        prog = 6'd7;
        ena  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            next_cyc;
            ena = 1'b0;
        end
        #1;
        total++;
        if (step_valid !== 1'b1 || step !== 7'd38) begin
            bad++; $display("FAIL mid_pass_before_reset got sv=%b step=%0d exp 1 38", step_valid, step);
        end
        reset = 1'b1;
        next_cyc;
        reset = 1'b0;
        exp_ovr = 0;
        #1;
        total++;
        if (step_valid !== 1'b0 || busy !== 1'b0 || ucode_addr !== 14'h0 || done !== 1'b0 ||
            ovr_cnt !== 8'(exp_ovr)) begin
            bad++; $display("FAIL reset_mid got sv=%b busy=%b addr=%h done=%b cnt=%0d exp 0 0 0000 0 0",
                            step_valid, busy, ucode_addr, done, ovr_cnt);
        end
        repeat (3) begin
            next_cyc;
            total++;
            if (step_valid !== 1'b0 || ucode_we !== 1'b0) begin
                bad++; $display("FAIL reset_mid_quiet got sv=%b we=%b exp 0 0", step_valid, ucode_we);
            end
        end
        run_pass(6'd2, 0, 6'd0, 0, 0);
        next_cyc;
    endtask

    initial begin
        reset           = 1'b1;
        ena             = 1'b0;
        prog            = 6'd0;
        ovr_clr         = 1'b0;
        ld_bus.ld_mode  = 1'b0;
        ld_bus.ld_addr  = '0;
        ld_bus.ld_data  = '0;
        ld_bus.ld_valid = 1'b0;

        test_reset;
        test_pass;
        test_prog_change;
        test_overrun;
        test_load;
        test_ld_during_run;
        test_reset_mid;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mv_ucode_seq.md
MV_UCODE_SEQ -- requirements
Module: mv_ucode_seq

Interface
REQ-001 Parameters: none; all widths and counts come from mv_pkg.
REQ-002 clk  in  1  system clock; the only clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ena  in  1  sample strobe; one-cycle pulse that starts one 128-step microcode pass.
REQ-005 prog  in  6  reverb program number; sampled only at pass start.
REQ-006 ld_mode  in  1  host requests microcode load access.
REQ-007 ld_addr  in  13  microcode write address.
REQ-008 ld_data  in  16  microcode write data.
REQ-009 ld_valid  in  1  write word valid.
REQ-010 ld_ready  out  1  write word accepted when ld_valid & ld_ready.
REQ-011 ovr_clr  in  1  clears the overrun counter.
REQ-012 ucode_addr  out  14  SPRAM address, {1'b0, 13-bit address}.
REQ-013 ucode_wdata  out  16  SPRAM write data.
REQ-014 ucode_we  out  1  SPRAM write enable.
REQ-015 step  out  7  index of the microcode word on the SPRAM output this cycle.
REQ-016 step_valid  out  1  SPRAM DATAOUT holds word `step` of the latched program.
REQ-017 done  out  1  one-cycle pulse with the final step_valid of a pass.
REQ-018 busy  out  1  high in RUN, DRAIN and LOAD.
REQ-019 overrun  out  1  one-cycle pulse when an ena is dropped.
REQ-020 ovr_cnt  out  8  saturating count of dropped ena pulses.

Function
REQ-021 The FSM states SHALL be IDLE, RUN, DRAIN and LOAD.
REQ-022 In IDLE, ena SHALL latch prog into rprog, clear iaddr and move to RUN; ena has priority over ld_mode in the same cycle.
REQ-023 In IDLE, ld_mode=1 with ena=0 SHALL move to LOAD.
REQ-024 In RUN, ucode_addr SHALL be {1'b0, rprog, iaddr}, and iaddr SHALL increment every cycle.
REQ-025 After issuing iaddr=127, the FSM SHALL move to DRAIN for one cycle and then to IDLE.
REQ-026 step_valid SHALL be asserted exactly one cycle after each RUN address issue (SPRAM latency 1), with step equal to the issued iaddr.
REQ-027 One pass SHALL produce 128 consecutive step_valid cycles, and done SHALL coincide with step=127 (the DRAIN cycle).
REQ-028 The ena-to-first-step_valid latency SHALL be 2 cycles, and ena-to-done SHALL be 129 cycles.
REQ-029 In LOAD:
- ld_ready=1, ucode_addr={1'b0, ld_addr}, ucode_wdata=ld_data, ucode_we=ld_valid.
- In all other states ld_ready=0 and ucode_we=0.
REQ-030 LOAD SHALL exit to IDLE in the cycle after ld_mode is sampled low; a word presented in that exit cycle is not written.
REQ-031 If ld_mode rises during RUN or DRAIN, the pass SHALL complete and LOAD SHALL be entered from IDLE.
REQ-032 An ena in RUN, DRAIN or LOAD SHALL be dropped, SHALL pulse overrun the next cycle, and SHALL leave the FSM unaffected.
REQ-033 A prog change during a pass SHALL have no effect until the next accepted ena.
REQ-034 Outside RUN and LOAD, ucode_addr SHALL hold {1'b0, rprog, 7'd0}.

Reset
REQ-035 Reset SHALL force:
- state=IDLE, rprog=0, iaddr=0.
- step=0, step_valid=0, done=0, busy=0, overrun=0, ld_ready=0, ucode_we=0.
- ucode_addr=0, ucode_wdata=0, ovr_cnt=0.
REQ-036 Reset asserted mid-pass or mid-load SHALL abort the operation with no further step_valid or ucode_we.

Configuration
REQ-037 With MV_SEQ_OVRCNT_EN defined:
- ovr_cnt SHALL increment on each overrun pulse and saturate at 255.
- ovr_clr SHALL zero ovr_cnt, with priority over a simultaneous increment.
REQ-038 Without MV_SEQ_OVRCNT_EN, ovr_cnt SHALL be constant 0 and ovr_clr SHALL be ignored; the overrun pulse remains.

Structure
REQ-039 mv_pkg SHALL hold:
- the state enum;
- MV_STEPS=128, MV_STEP_W=7, MV_PROG_W=6, MV_UADDR_W=13, MV_UDATA_W=16.
REQ-040 The saturating counter SHALL be sub-module mv_ovr_cnt, instantiated only under MV_SEQ_OVRCNT_EN.

Verification
REQ-041 prog=5, ena pulse at cycle 0: ucode_addr 0x0280..0x02FF on cycles 1..128; step_valid on cycles 2..129 with step 0..127; done at cycle 129.
REQ-042 prog changed from 5 to 9 at cycle 50 of a pass: all addresses stay in 0x0280..0x02FF; the next ena gives addresses 0x0480 onward.
REQ-043 ena at cycles 0 and 60: overrun pulses at cycle 61; only one done; ovr_cnt=1 (macro on) or 0 (macro off).
REQ-044 ld_mode=1 in IDLE, three words (0x0001/0xAAAA, 0x0002/0x5555, 0x1FFF/0x1234): three ucode_we cycles with matching address and data; an ena during LOAD pulses overrun and starts no pass.
REQ-045 ld_mode raised at pass cycle 10: ld_ready stays 0 until after done, then goes to 1.
REQ-046 Reset at pass cycle 40: the next cycle shows step_valid=0, busy=0, ucode_addr=0; a new ena runs a full 128-step pass.
